// File: rtl/gdo.sv
// gdo: fixed-point helpers shared by the backprop datapath.
package gdo;

    localparam int FRAC_BITS = 8;

    function automatic logic signed [63:0] gdo_mult(input logic signed [63:0] a, input logic signed [63:0] b);
        logic signed [63:0] p;
        p = a * b;
        return p >>> FRAC_BITS;
    endfunction

    function automatic logic signed [63:0] gdo_sat_add(input logic signed [63:0] a, input logic signed [63:0] b,
                                                       input int w = 16);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction

endpackage

// File: rtl/matrix_deskew.sv
// matrix_deskew: undoes matrix-prep skew; lane c is delayed size-1-c cycles so rows line up.
module matrix_deskew #(
    parameter int data_size = 16,
    parameter int size      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [data_size*size-1:0] input_stream,
    output logic [data_size*size-1:0] output_stream
);

    genvar c;
    for (c = 0; c < size; c++) begin : g_lane
        localparam int depth = size - 1 - c;
        if (depth == 0) begin : g_pass
            assign output_stream[data_size*(size-c)-1 -: data_size] = input_stream[data_size*(size-c)-1 -: data_size];
        end else begin : g_pipe
            logic [data_size-1:0] pipe [depth];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe <= '{default: '0};
                end else begin
                    pipe[0] <= input_stream[data_size*(size-c)-1 -: data_size];
                    for (int i = 1; i < depth; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign output_stream[data_size*(size-c)-1 -: data_size] = pipe[depth-1];
        end
    end

endmodule

// File: rtl/delta_vecmat_accumulator.sv
// delta_vecmat_accumulator: r[j] = sum_r a[r]*B[r][j] over a deskewed z-to-z derivative stream,
// held under a valid/ready handshake.
module delta_vecmat_accumulator
    import gdo::*;
#(
    parameter int data_size = 16,
    parameter int size      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_new_layer,
    input  logic [data_size*size-1:0] diff_cost,
    input  logic [data_size*size-1:0] diff_z_to_z,
    output logic [data_size*size-1:0] result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      overrun
);

    if (size < 2) begin : g_bad_size
        $error("delta_vecmat_accumulator: size must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, FILL, ACCUM, DONE} state_t;

    localparam int cw = $clog2(size);
    localparam logic [cw-1:0] last_beat = cw'(size - 1);
    localparam logic [cw-1:0] fill_init = cw'((size > 2) ? size - 3 : 0);

    state_t                      state;
    logic [cw-1:0]               beat;
    logic [cw-1:0]               fill;
    logic [data_size*size-1:0]   aligned;
    logic [data_size*size-1:0]   res_next;
    logic signed [data_size-1:0] a_reg    [size];
    logic signed [data_size-1:0] acc      [size];
    logic signed [data_size-1:0] acc_next [size];
    logic signed [data_size-1:0] a_in     [size];
    logic signed [data_size-1:0] b_row    [size];
    logic signed [data_size-1:0] p_t      [size];
    logic                        accept;

    matrix_deskew #(.data_size(data_size), .size(size)) u_deskew (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_stream (diff_z_to_z),
        .output_stream(aligned)
    );

    // A start in DONE is only honoured when it coincides with the handshake.
    assign accept    = start_new_layer && (state == IDLE || (state == DONE && out_ready));
    assign busy      = state != IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        res_next = '0;
        for (int j = 0; j < size; j++) begin
            a_in[j]     = diff_cost[data_size*(size-j)-1 -: data_size];
            b_row[j]    = aligned[data_size*(size-j)-1 -: data_size];
            p_t[j]      = data_size'(gdo_mult(64'(a_reg[beat]), 64'(b_row[j])));
            acc_next[j] = (beat == '0) ? p_t[j] : data_size'(gdo_sat_add(64'(acc[j]), 64'(p_t[j]), data_size));
            res_next[data_size*(size-j)-1 -: data_size] = acc_next[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat    <= '0;
            fill    <= '0;
            overrun <= 1'b0;
            result  <= '0;
            a_reg   <= '{default: '0};
            acc     <= '{default: '0};
        end else begin
            if (start_new_layer && !accept) overrun <= 1'b1;
            if (accept) begin
                a_reg <= a_in;
                state <= (size == 2) ? ACCUM : FILL;
                fill  <= fill_init;
                beat  <= '0;
            end else begin
                case (state)
                    FILL: begin
                        if (fill == '0) state <= ACCUM;
                        else fill <= fill - 1'b1;
                    end
                    ACCUM: begin
                        acc  <= acc_next;
                        beat <= beat + 1'b1;
                        if (beat == last_beat) begin
                            state  <= DONE;
                            beat   <= '0;
                            result <= res_next;
                        end
                    end
                    DONE: if (out_ready) state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delta_vecmat_accumulator.sv
// tb_delta_vecmat_accumulator: scoreboard bench; expected results queued at start, checked at handshake.
module tb_delta_vecmat_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_new_layer;
    logic [47:0] diff_cost;
    logic [47:0] diff_z_to_z;
    logic [47:0] result;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overrun;

    logic [15:0] cur_a [3];
    logic [15:0] cur_b [3][3];
    logic [47:0] q [$];
    logic [47:0] last_exp;
    int          tests = 0;
    int          fails = 0;

    delta_vecmat_accumulator #(.data_size(16), .size(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_new_layer(start_new_layer),
        .diff_cost      (diff_cost),
        .diff_z_to_z    (diff_z_to_z),
        .result         (result),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] model();
        logic [47:0] v;
        int          acc [3];
        v = '0;
        for (int j = 0; j < 3; j++) begin
            for (int r = 0; r < 3; r++) begin
                int p;
                int p16;
                int s;
                p   = (int'($signed(cur_a[r])) * int'($signed(cur_b[r][j]))) >>> 8;
                p16 = int'(shortint'(p));
                s   = (r == 0) ? p16 : acc[j] + p16;
                acc[j] = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
            end
            v[16*(3-j)-1 -: 16] = 16'(acc[j]);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pass(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                            input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2, input bit ident);
        cur_a[0] = a0; cur_a[1] = a1; cur_a[2] = a2;
        for (int r = 0; r < 3; r++) begin
            cur_b[r][0] = ident ? ((r == 0) ? 16'h0100 : 16'h0) : b0;
            cur_b[r][1] = ident ? ((r == 1) ? 16'h0100 : 16'h0) : b1;
            cur_b[r][2] = ident ? ((r == 2) ? 16'h0100 : 16'h0) : b2;
        end
    endtask

    // Drives one skewed pass starting now; optional stray start at extra_k, optional reset at rst_k.
    task automatic run_pass(input int extra_k, input int rst_k, input bit chk_lat);
        last_exp = model();
        q.push_back(last_exp);
        for (int k = 0; k < 5; k++) begin
            start_new_layer = (k == 0) || (k == extra_k);
            diff_cost = '1;
            if (k == 0) diff_cost = {cur_a[0], cur_a[1], cur_a[2]};
            for (int c = 0; c < 3; c++) begin
                int r;
                r = k - c;
                diff_z_to_z[16*(3-c)-1 -: 16] = (r >= 0 && r < 3) ? cur_b[r][c] : 16'h0;
            end
            if (k > 0 && (rst_k < 0 || k < rst_k)) check("busy_in_pass", 48'(busy), 48'd1);
            if (chk_lat && k > 0) check("latency_low", 48'(out_valid), 48'd0);
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                check("rst_result", result, 48'd0);
                check("rst_valid", 48'(out_valid), 48'd0);
                check("rst_busy", 48'(busy), 48'd0);
                check("rst_overrun", 48'(overrun), 48'd0);
                void'(q.pop_back());
                rst_n = 1'b1;
            end
            step();
        end
        start_new_layer = 1'b0;
        diff_z_to_z = '0;
        if (chk_lat) check("latency_high", 48'(out_valid), 48'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) check("spurious_valid", 48'(out_valid), 48'd0);
            else check("result", result, q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start_new_layer = 1'b0;
        diff_cost = '0;
        diff_z_to_z = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 48'd0);
        check("reset_valid", 48'(out_valid), 48'd0);
        check("reset_busy", 48'(busy), 48'd0);
        check("reset_overrun", 48'(overrun), 48'd0);
        rst_n = 1'b1;
        step();

        set_pass(16'h0100, 16'h0200, 16'h0300, 0, 0, 0, 1'b1);
        run_pass(-1, -1, 1'b1);
        repeat (2) step();

        set_pass(16'h0080, 16'hFF00, 16'h0200, 16'h0200, 16'h0100, 16'h0400, 1'b0);
        run_pass(-1, -1, 1'b1);
        repeat (2) step();

        set_pass(16'h7F00, 16'h7F00, 16'h7F00, 16'h0100, 16'h0100, 16'h0100, 1'b0);
        run_pass(-1, -1, 1'b0);
        repeat (2) step();
        set_pass(16'h8100, 16'h8100, 16'h8100, 16'h0100, 16'h0100, 16'h0100, 1'b0);
        run_pass(-1, -1, 1'b0);
        repeat (2) step();
        set_pass(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 1'b0);
        run_pass(-1, -1, 1'b0);
        repeat (2) step();

        out_ready = 1'b0;
        set_pass(16'h0080, 16'hFF00, 16'h0200, 16'h0200, 16'h0100, 16'h0400, 1'b0);
        run_pass(3, -1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            start_new_layer = (i == 2);
            check("hold_result", result, last_exp);
            check("hold_valid", 48'(out_valid), 48'd1);
            step();
        end
        start_new_layer = 1'b0;
        check("overrun_set", 48'(overrun), 48'd1);
        out_ready = 1'b1;
        step();
        check("release_valid", 48'(out_valid), 48'd0);
        check("release_busy", 48'(busy), 48'd0);
        step();

        set_pass(16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0200, 16'h0300, 1'b0);
        run_pass(-1, -1, 1'b0);
        check("b2b_busy", 48'(busy), 48'd1);
        set_pass(16'hFF80, 16'h0040, 16'h0500, 16'h0100, 16'h0200, 16'h0300, 1'b0);
        run_pass(-1, -1, 1'b0);
        repeat (2) step();

        set_pass(16'h0080, 16'hFF00, 16'h0200, 16'h0200, 16'h0100, 16'h0400, 1'b0);
        run_pass(-1, 3, 1'b0);
        repeat (3) step();
        set_pass(16'h0100, 16'h0200, 16'h0300, 0, 0, 0, 1'b1);
        run_pass(-1, -1, 1'b1);

        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        check("drain", 48'(q.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
